// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between the two requesters.
// MEM_ARB_RR_EN selects round-robin on a tie; otherwise port 0 has fixed priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
`ifdef MEM_ARB_RR_EN
  input  logic last_grant,
`endif
  output logic grant_valid,
  output logic grant_idx
);

  always_comb begin
    grant_valid = valid0 | valid1;
    grant_idx   = PORT0;
    if (valid0 && valid1) begin
`ifdef MEM_ARB_RR_EN
      // Tie goes to whichever port was not served last.
      grant_idx = (last_grant == PORT0) ? PORT1 : PORT0;
`else
      grant_idx = PORT0;
`endif
    end else if (valid1) begin
      grant_idx = PORT1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one valid/ready memory port; one transfer in flight.
// Build option: define MEM_ARB_RR_EN for round-robin tie-breaking (default fixed priority).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned ADDR_LINES = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req0_valid_i,
  output logic                  req0_ready_o,
  input  logic                  req0_wr_rd_i,
  input  logic [ADDR_LINES-1:0] req0_addr_i,
  input  logic [WIDTH-1:0]      req0_wr_data_i,
  output logic                  req0_done_o,
  output logic [WIDTH-1:0]      req0_rd_data_o,
  input  logic                  req1_valid_i,
  output logic                  req1_ready_o,
  input  logic                  req1_wr_rd_i,
  input  logic [ADDR_LINES-1:0] req1_addr_i,
  input  logic [WIDTH-1:0]      req1_wr_data_i,
  output logic                  req1_done_o,
  output logic [WIDTH-1:0]      req1_rd_data_o,
  output logic                  mem_valid_o,
  output logic                  mem_wr_rd_o,
  output logic [ADDR_LINES-1:0] mem_addr_o,
  output logic [WIDTH-1:0]      mem_wr_data_o,
  input  logic [WIDTH-1:0]      mem_rd_data_i,
  input  logic                  mem_ready_i
);

  // DEPTH is informational; only reject configurations the address bus cannot reach.
  if (DEPTH > (32'd1 << ADDR_LINES)) begin : g_depth_chk
    $error("mem_arbiter: DEPTH exceeds address space");
  end

  arb_state_e            state;
  logic                  owner;
  logic                  grant_valid;
  logic                  grant_idx;
  logic                  sel_wr_rd;
  logic [ADDR_LINES-1:0] sel_addr;
  logic [WIDTH-1:0]      sel_wr_data;

`ifdef MEM_ARB_RR_EN
  logic last_grant;

  mem_arb_pick u_pick (
    .valid0      (req0_valid_i),
    .valid1      (req1_valid_i),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );
`else
  mem_arb_pick u_pick (
    .valid0      (req0_valid_i),
    .valid1      (req1_valid_i),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );
`endif

  assign sel_wr_rd   = (grant_idx == PORT1) ? req1_wr_rd_i   : req0_wr_rd_i;
  assign sel_addr    = (grant_idx == PORT1) ? req1_addr_i    : req0_addr_i;
  assign sel_wr_data = (grant_idx == PORT1) ? req1_wr_data_i : req0_wr_data_i;

  // Accept is combinational so a requester sees ready in the same cycle it is chosen.
  assign req0_ready_o = !rst_i && (state == IDLE) && grant_valid && (grant_idx == PORT0);
  assign req1_ready_o = !rst_i && (state == IDLE) && grant_valid && (grant_idx == PORT1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      owner          <= PORT0;
      mem_valid_o    <= 1'b0;
      mem_wr_rd_o    <= 1'b0;
      mem_addr_o     <= '0;
      mem_wr_data_o  <= '0;
      req0_done_o    <= 1'b0;
      req1_done_o    <= 1'b0;
      req0_rd_data_o <= '0;
      req1_rd_data_o <= '0;
`ifdef MEM_ARB_RR_EN
      last_grant     <= PORT1;
`endif
    end else begin
      req0_done_o <= 1'b0;
      req1_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner         <= grant_idx;
            mem_valid_o   <= 1'b1;
            mem_wr_rd_o   <= sel_wr_rd;
            mem_addr_o    <= sel_addr;
            mem_wr_data_o <= sel_wr_data;
            state         <= XFER;
          end
        end
        XFER: begin
          if (mem_ready_i) begin
            if (!mem_wr_rd_o) begin
              if (owner == PORT1) req1_rd_data_o <= mem_rd_data_i;
              else                req0_rd_data_o <= mem_rd_data_i;
            end
            req0_done_o   <= (owner == PORT0);
            req1_done_o   <= (owner == PORT1);
            mem_valid_o   <= 1'b0;
            mem_wr_rd_o   <= 1'b0;
            mem_addr_o    <= '0;
            mem_wr_data_o <= '0;
            state         <= DONE;
          end
        end
        DONE: begin
`ifdef MEM_ARB_RR_EN
          last_grant <= owner;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level model plus directed literal checks.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int unsigned W  = 8;
  localparam int unsigned AL = 10;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          v [2];
  logic          wr [2];
  logic [AL-1:0] ad [2];
  logic [W-1:0]  wd [2];
  logic          r0, r1, d0, d1;
  logic [W-1:0]  rd0, rd1;
  logic          mem_valid, mem_wr_rd, mem_ready;
  logic [AL-1:0] mem_addr;
  logic [W-1:0]  mem_wr_data, mem_rd_data;

  logic [W-1:0]  tb_mem  [1024];
  logic [W-1:0]  ref_mem [1024];

  int checks = 0;
  int errors = 0;

  // model of the transfer in flight
  bit            have, hs;
  int            tp, last;
  logic          twr;
  logic [AL-1:0] ta;
  logic [W-1:0]  td;
  logic [W-1:0]  mrd [2];

  int  rdy_mode;   // 0: ready tied 1, 1: random, 2: held 0
  bit  cont;
  int  auto_pct;
  int  dut_grants[$];

  always #5 clk_i = ~clk_i;

  assign mem_rd_data = tb_mem[mem_addr];

  mem_arbiter dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req0_valid_i   (v[0]),
    .req0_ready_o   (r0),
    .req0_wr_rd_i   (wr[0]),
    .req0_addr_i    (ad[0]),
    .req0_wr_data_i (wd[0]),
    .req0_done_o    (d0),
    .req0_rd_data_o (rd0),
    .req1_valid_i   (v[1]),
    .req1_ready_o   (r1),
    .req1_wr_rd_i   (wr[1]),
    .req1_addr_i    (ad[1]),
    .req1_wr_data_i (wd[1]),
    .req1_done_o    (d1),
    .req1_rd_data_o (rd1),
    .mem_valid_o    (mem_valid),
    .mem_wr_rd_o    (mem_wr_rd),
    .mem_addr_o     (mem_addr),
    .mem_wr_data_o  (mem_wr_data),
    .mem_rd_data_i  (mem_rd_data),
    .mem_ready_i    (mem_ready)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(logic a, logic b, int lg);
    if (a && b) begin
`ifdef MEM_ARB_RR_EN
      return (lg == 0) ? 1 : 0;
`else
      return (lg == lg) ? 0 : 0;
`endif
    end
    if (a) return 0;
    if (b) return 1;
    return -1;
  endfunction

  task automatic set_req(input int p, input logic w, input logic [AL-1:0] a, input logic [W-1:0] d);
    v[p] = 1'b1; wr[p] = w; ad[p] = a; wd[p] = d;
  endtask

  task automatic new_req(input int p);
    logic [AL-1:0] a;
    a = ($urandom_range(7) == 0) ? 10'h3FF : AL'($urandom_range(15));
    set_req(p, 1'($urandom_range(1)), a, W'($urandom));
  endtask

  // One clock: compare at negedge+1 against the model, advance the model, move to next negedge.
  task automatic step();
    int            win, acc;
    bit            exp_mv, mwrite;
    logic [AL-1:0] wa;
    logic [W-1:0]  wdat;
    mem_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : ($urandom_range(99) < 70);
    #1;
    if (rst_i) begin
      have = 0; hs = 0; last = 1; mrd[0] = '0; mrd[1] = '0;
    end
    win    = (rst_i || have) ? -1 : pick(v[0], v[1], last);
    exp_mv = have && !hs;
    chk("ready0", 32'(r0), 32'(win == 0));
    chk("ready1", 32'(r1), 32'(win == 1));
    chk("mem_valid", 32'(mem_valid), 32'(exp_mv));
    chk("mem_wr_rd", 32'(mem_wr_rd), exp_mv ? 32'(twr) : 32'd0);
    chk("mem_addr", 32'(mem_addr), exp_mv ? 32'(ta) : 32'd0);
    chk("mem_wr_data", 32'(mem_wr_data), exp_mv ? 32'(td) : 32'd0);
    chk("done0", 32'(d0), 32'(have && hs && tp == 0));
    chk("done1", 32'(d1), 32'(have && hs && tp == 1));
    chk("rd_data0", 32'(rd0), 32'(mrd[0]));
    chk("rd_data1", 32'(rd1), 32'(mrd[1]));
    if (r0) dut_grants.push_back(0);
    if (r1) dut_grants.push_back(1);
    mwrite = mem_valid && mem_ready && mem_wr_rd;
    wa = mem_addr; wdat = mem_wr_data;
    acc = -1;
    if (!rst_i) begin
      if (!have) begin
        if (win >= 0) begin
          have = 1; hs = 0; tp = win; acc = win;
          twr = wr[win]; ta = ad[win]; td = wd[win];
        end
      end else if (!hs) begin
        if (mem_ready) begin
          hs = 1;
          if (twr) ref_mem[ta] = td;
          else     mrd[tp] = ref_mem[ta];
        end
      end else begin
        have = 0; last = tp;
      end
    end
    @(posedge clk_i);
    if (mwrite) tb_mem[wa] = wdat;
    @(negedge clk_i);
    if (acc >= 0) begin
      v[acc] = 1'b0;
      if (cont) new_req(acc);
    end
    for (int p = 0; p < 2; p++)
      if (!v[p] && auto_pct > 0 && $urandom_range(99) < auto_pct) new_req(p);
  endtask

  task automatic drain(input int budget);
    int n;
    cont = 0; auto_pct = 0; n = 0;
    while ((v[0] || v[1] || have) && n < budget) begin
      step();
      n++;
    end
    chk("drain_busy", 32'(v[0] || v[1] || have), 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_g [4];
    int n;
    for (int i = 0; i < 1024; i++) begin tb_mem[i] = '0; ref_mem[i] = '0; end
    for (int p = 0; p < 2; p++) begin v[p] = 0; wr[p] = 0; ad[p] = '0; wd[p] = '0; end
    mem_ready = 1'b0; rdy_mode = 0; cont = 0; auto_pct = 0;
    have = 0; hs = 0; last = 1; tp = 0; twr = 0; ta = '0; td = '0; mrd[0] = '0; mrd[1] = '0;
    rst_i = 1'b1;
    @(negedge clk_i);
    step();
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_done0", 32'(d0), 32'd0);
    step();
    rst_i = 1'b0;
    step();

    // port0 write 5 <- A5 with memory always ready
    set_req(0, 1'b1, 10'h005, 8'hA5);
    step();
    chk("t1_grant", 32'(dut_grants[$]), 32'd0);
    chk("t1_mem_valid", 32'(mem_valid), 32'd1);
    chk("t1_mem_wr_rd", 32'(mem_wr_rd), 32'd1);
    chk("t1_mem_addr", 32'(mem_addr), 32'h005);
    chk("t1_mem_data", 32'(mem_wr_data), 32'hA5);
    step();
    chk("t1_done_hi", 32'(d0), 32'd1);
    chk("t1_valid_lo", 32'(mem_valid), 32'd0);
    step();
    chk("t1_done_lo", 32'(d0), 32'd0);

    // port1 reads it back
    set_req(1, 1'b0, 10'h005, 8'h00);
    step();
    step();
    chk("t2_done1", 32'(d1), 32'd1);
    chk("t2_rd1", 32'(rd1), 32'hA5);
    chk("t2_rd0", 32'(rd0), 32'h00);
    step();

    // both ports requesting continuously
`ifdef MEM_ARB_RR_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    dut_grants.delete();
    cont = 1;
    new_req(0);
    new_req(1);
    n = 0;
    while (dut_grants.size() < 4 && n < 40) begin step(); n++; end
    chk("t3_grant_cnt", 32'(dut_grants.size()), 32'd4);
    for (int i = 0; i < 4 && i < dut_grants.size(); i++)
      chk($sformatf("t3_grant%0d", i), 32'(dut_grants[i]), 32'(exp_g[i]));
    drain(50);

    // memory stalls for 5 cycles
    rdy_mode = 2;
    set_req(0, 1'b1, 10'h007, 8'h3C);
    step();
    set_req(1, 1'b0, 10'h002, 8'h00);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_valid", 32'(mem_valid), 32'd1);
      chk("t4_addr", 32'(mem_addr), 32'h007);
      chk("t4_done0", 32'(d0), 32'd0);
    end
    rdy_mode = 0;
    drain(50);

    // reset while the transfer is outstanding
    rdy_mode = 2;
    set_req(0, 1'b0, 10'h009, 8'h00);
    step();
    chk("t5_xfer_valid", 32'(mem_valid), 32'd1);
    rst_i = 1'b1;
    #1;
    chk("t5_async_valid", 32'(mem_valid), 32'd0);
    chk("t5_async_addr", 32'(mem_addr), 32'd0);
    step();
    step();
    rst_i = 1'b0;
    rdy_mode = 0;
    set_req(1, 1'b1, 10'h3FF, 8'hFF);
    step();
    chk("t5_fresh_grant", 32'(dut_grants[$]), 32'd1);
    chk("t5_fresh_valid", 32'(mem_valid), 32'd1);
    drain(20);

    // top-address read back
    set_req(0, 1'b0, 10'h3FF, 8'h00);
    drain(20);
    chk("t6_rd0_top", 32'(rd0), 32'hFF);

    // randomized traffic with a randomly stalling memory
    rdy_mode = 1;
    auto_pct = 40;
    for (int i = 0; i < 1500; i++) step();
    rdy_mode = 0;
    drain(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single valid/ready port of `memory_backdoor` between two front-door masters. It accepts one request at a time, registers it, and drives the memory port until the memory handshakes. It then returns a one-cycle completion pulse, plus read data for reads, to the requester that owned the transfer. It sits directly in front of `memory_backdoor`. Backdoor `$readmemh`/`$writememh` access to `dut.mem` is unaffected.

## Interface
- `WIDTH`, 8, data width (matches memory)
- `DEPTH`, 1024, memory locations (documentation only; no range check)
- `ADDR_LINES`, 10, address width
- `clk_i` in 1: single clock, all logic on posedge
- `rst_i` in 1: asynchronous, active-high reset
- `reqN_valid_i` in 1 (N=0,1): request pending; held until `reqN_ready_o`
- `reqN_ready_o` out 1: request accepted this cycle
- `reqN_wr_rd_i` in 1: 1=write, 0=read
- `reqN_addr_i` in ADDR_LINES: target address
- `reqN_wr_data_i` in WIDTH: write data
- `reqN_done_o` out 1: one-cycle completion pulse
- `reqN_rd_data_o` out WIDTH: read data, valid with `reqN_done_o` for reads
- `mem_valid_o` out 1: to memory `valid_i`
- `mem_wr_rd_o` out 1: to memory `wr_rd_i`
- `mem_addr_o` out ADDR_LINES: to memory `addr_i`
- `mem_wr_data_o` out WIDTH: to memory `wr_data_i`
- `mem_rd_data_i` in WIDTH: from memory `rd_data_o`
- `mem_ready_i` in 1: from memory `ready_o`

## Operation
- FSM states: IDLE, XFER, DONE. Reset state is IDLE.
- **IDLE**
  - If any `reqN_valid_i`, select a winner (see Configuration).
  - `reqW_ready_o`=1 combinationally for the winner only, gated low while `rst_i`=1.
  - At the edge: latch wr_rd/addr/wr_data and owner index, go to XFER.
- **XFER**
  - `mem_valid_o`=1, with the latched fields driven on the `mem_*` outputs.
  - Stay until `mem_valid_o && mem_ready_i` at an edge.
  - On that edge: for a read, capture `mem_rd_data_i` into the owner's `rd_data` register; go to DONE.
- **DONE**
  - `mem_valid_o`=0 and `mem_*` fields return to 0.
  - `reqW_done_o`=1 for one cycle. Update `last_grant` to the owner. Go to IDLE.
- `reqN_rd_data_o` holds its last read value. It is unchanged by writes and by the other port's reads.
- Reset mid-operation: return to IDLE immediately. The transfer is dropped with no done pulse, and `mem_valid_o` falls asynchronously.
- A requester that drops valid before ready is a protocol violation. It is not checked, and the arbiter simply ignores it.
- Out-of-range address (≥DEPTH) is passed through unchanged.

## Timing
- All outputs reset to 0.
- Accept edge T. `mem_valid_o` is high from T.
- With `mem_ready_i`=1 immediately, the memory handshake is at edge T+1 and `done` is high during T+1..T+2.
- Minimum spacing between accepts is 3 cycles. Each memory wait cycle adds 1.
- `done` and `rd_data` are registered. `ready` is combinational from state, valids and `last_grant`.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin.
  - On a tie, the port ≠ `last_grant` wins.
  - `last_grant` resets to 1, so port 0 wins the first tie.
- Undefined: fixed priority. Port 0 always wins a tie, and `last_grant` is not implemented.

## Structure
- `mem_arb_pkg`: FSM state encoding (IDLE=2'd0, XFER=2'd1, DONE=2'd2), port index constants `PORT0`/`PORT1`.
- One sub-module, `mem_arb_pick`, is natural. It is combinational: inputs are the two valids and `last_grant`; outputs are `grant_valid` and `grant_idx`, with the macro-dependent policy inside it.

## Test plan
- Port0 write addr 10'h005 data 8'hA5, `mem_ready_i` tied 1:
  - `req0_ready_o` pulses at T.
  - `mem_*` = {1,1,5,A5} for one cycle.
  - `req0_done_o` pulses at T+1..T+2.
- Port1 read addr 10'h005 after that write, memory returning 8'hA5 → `req1_rd_data_o`=8'hA5 with `req1_done_o`. `req0_rd_data_o` stays 0.
- Both ports request continuously, 4 transfers:
  - `MEM_ARB_RR_EN` defined: grant order 0,1,0,1.
  - Undefined: 0,0,0,0.
- `mem_ready_i` held 0 for 5 cycles in XFER → `mem_valid_o` and fields stay stable, no `done`, the other port gets no `ready`.
- Assert `rst_i` while in XFER:
  - All outputs go to 0 asynchronously, no `done`.
  - After release, a fresh request is accepted normally.
- Write addr 10'h3FF data 8'hFF then read addr 10'h3FF → read returns 8'hFF (top-address boundary).
